// File: rtl/debug_controller_pkg.sv
// Shared debug-path constants: host command opcodes, sequencer states and
// the phase decoder's phase encodings.
package debug_controller_pkg;

    localparam logic [2:0] PHI_FETCH  = 3'd0;
    localparam logic [2:0] PHI_DECODE = 3'd1;
    localparam logic [2:0] PHI_EXEC   = 3'd2;
    localparam logic [2:0] PHI_MEM    = 3'd3;
    localparam logic [2:0] PHI_WB     = 3'd4;

    localparam logic [2:0] DBG_CMD_NOP      = 3'd0;
    localparam logic [2:0] DBG_CMD_STOP     = 3'd1;
    localparam logic [2:0] DBG_CMD_RUN      = 3'd2;
    localparam logic [2:0] DBG_CMD_STEP     = 3'd3;
    localparam logic [2:0] DBG_CMD_SET_BKP  = 3'd4;
    localparam logic [2:0] DBG_CMD_CLR_BKP  = 3'd5;
    localparam logic [2:0] DBG_CMD_SET_MODE = 3'd6;

    typedef enum logic [2:0] {
        DBG_ST_RUN,
        DBG_ST_HALTING,
        DBG_ST_HALTED,
        DBG_ST_STEP_REQ,
        DBG_ST_STEP_REL,
        DBG_ST_RESUME
    } dbg_state_t;

    // Index width that stays legal for a single-slot bank.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_controller_bkp_match.sv
// Breakpoint bank: NUM_BKP address/enable slots compared in parallel against
// the PC, with the lowest matching slot reported as the hit index.
module debug_bkp_match
    import debug_controller_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int NUM_BKP = 4,
    parameter int IDX_W   = idx_width(NUM_BKP)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set,
    input  logic              i_clr,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_match_any,
    output logic [IDX_W-1:0]  o_hit_idx
);

    logic [ADDR_W-1:0]  r_addr [NUM_BKP];
    logic [NUM_BKP-1:0] r_en;
    logic [NUM_BKP-1:0] w_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en <= '0;
            for (int unsigned i = 0; i < NUM_BKP; i++) begin
                r_addr[i] <= '0;
            end
        end else if (i_set) begin
            r_addr[i_idx] <= i_addr;
            r_en[i_idx]   <= 1'b1;
        end else if (i_clr) begin
            r_en[i_idx]   <= 1'b0;
        end
    end

    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < NUM_BKP; i++) begin
            w_hit[i] = r_en[i] && (r_addr[i] == i_pc);
        end
    end

    // Scan downwards so the lowest matching slot is the last one written.
    always_comb begin
        o_hit_idx = '0;
        for (int unsigned i = NUM_BKP; i > 0; i--) begin
            if (w_hit[i-1]) o_hit_idx = IDX_W'(i - 1);
        end
    end

    assign o_match_any = |w_hit;

endmodule

// File: rtl/debug_controller.sv
// Host-facing debug sequencer: executes STOP/RUN/STEP commands, owns the PC
// breakpoints and runs the step REQ/ACK handshake with the phase decoder.
module debug_controller
    import debug_controller_pkg::*;
#(
    parameter  int ADDR_W  = 16,
    parameter  int NUM_BKP = 4,
    parameter  int CNT_W   = 8,
    localparam int IDX_W   = idx_width(NUM_BKP)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [2:0]        CMD_OP,
    input  logic [IDX_W-1:0]  CMD_IDX,
    input  logic [ADDR_W-1:0] CMD_ARG,
    input  logic [ADDR_W-1:0] PC,
    input  logic              STOPPED,
    input  logic              DEBUG_STEP_ACK,
    output logic              DEBUG_STOP,
    output logic              DEBUG_AT_BKP,
    output logic              DEBUG_STEP_REQ,
    output logic              DEBUG_MODE,
    output logic              HALTED,
    output logic              EVENT,
    output logic [IDX_W-1:0]  BKP_HIT
);

    dbg_state_t        r_state;
    logic              r_stop, r_at_bkp, r_req, r_mode, r_halted, r_event, r_skip;
    logic [IDX_W-1:0]  r_bkp_hit;
    logic [ADDR_W-1:0] r_skip_addr;
    logic [CNT_W-1:0]  r_count;

    logic              w_ready, w_acc, w_match_any, w_skip_set;
    logic              w_op_stop, w_op_run, w_op_step;
    logic [IDX_W-1:0]  w_hit_idx;
    logic [CNT_W-1:0]  w_step_arg;

    assign w_ready    = (r_state == DBG_ST_RUN) || (r_state == DBG_ST_HALTED);
    assign w_acc      = CMD_VALID && w_ready;
    assign w_op_stop  = w_acc && (CMD_OP == DBG_CMD_STOP);
    assign w_op_run   = w_acc && (CMD_OP == DBG_CMD_RUN);
    assign w_op_step  = w_acc && (CMD_OP == DBG_CMD_STEP);
    assign w_skip_set = w_op_run && (r_state == DBG_ST_HALTED);
    assign w_step_arg = CMD_ARG[CNT_W-1:0];

    debug_bkp_match #(
        .ADDR_W  (ADDR_W),
        .NUM_BKP (NUM_BKP),
        .IDX_W   (IDX_W)
    ) u_bkp_match (
        .i_clk       (CLK),
        .i_rst_n     (RESETN),
        .i_set       (w_acc && (CMD_OP == DBG_CMD_SET_BKP)),
        .i_clr       (w_acc && (CMD_OP == DBG_CMD_CLR_BKP)),
        .i_idx       (CMD_IDX),
        .i_addr      (CMD_ARG),
        .i_pc        (PC),
        .o_match_any (w_match_any),
        .o_hit_idx   (w_hit_idx)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= DBG_ST_RUN;
            r_stop      <= 1'b0;
            r_at_bkp    <= 1'b0;
            r_req       <= 1'b0;
            r_mode      <= 1'b0;
            r_halted    <= 1'b0;
            r_event     <= 1'b0;
            r_skip      <= 1'b0;
            r_bkp_hit   <= '0;
            r_skip_addr <= '0;
            r_count     <= '0;
        end else begin
            r_event  <= 1'b0;
            // Masking with the skip being set this cycle keeps AT_BKP low
            // from the very first cycle after RUN leaves a parked breakpoint.
            r_at_bkp <= w_match_any && !(r_skip || w_skip_set);

            if (w_skip_set) begin
                r_skip      <= 1'b1;
                r_skip_addr <= PC;
            end else if (r_skip && (PC != r_skip_addr)) begin
                r_skip      <= 1'b0;
            end

            if (w_acc && (CMD_OP == DBG_CMD_SET_MODE)) r_mode <= CMD_ARG[0];

            case (r_state)
                DBG_ST_RUN: begin
                    if (r_at_bkp && STOPPED) begin
                        r_bkp_hit <= w_hit_idx;
                        r_state   <= DBG_ST_HALTING;
                    end else if (w_op_stop) begin
                        r_stop    <= 1'b1;
                        r_state   <= DBG_ST_HALTING;
                    end
                end
                DBG_ST_HALTING: begin
                    if (STOPPED) begin
                        r_stop   <= 1'b1;
                        r_halted <= 1'b1;
                        r_event  <= 1'b1;
                        r_state  <= DBG_ST_HALTED;
                    end
                end
                DBG_ST_HALTED: begin
                    if (w_op_step) begin
                        r_count <= (w_step_arg == '0) ? CNT_W'(1) : w_step_arg;
                        r_req   <= 1'b1;
                        r_state <= DBG_ST_STEP_REQ;
                    end else if (w_op_run) begin
                        r_stop   <= 1'b0;
                        r_halted <= 1'b0;
                        r_state  <= DBG_ST_RESUME;
                    end
                end
                DBG_ST_STEP_REQ: begin
                    if (DEBUG_STEP_ACK) begin
                        r_req <= 1'b0;
                        if (r_count != '0) r_count <= r_count - CNT_W'(1);
                        r_state <= DBG_ST_STEP_REL;
                    end
                end
                DBG_ST_STEP_REL: begin
                    if (w_match_any) r_bkp_hit <= w_hit_idx;
                    if (!DEBUG_STEP_ACK) begin
                        if (r_count != '0) begin
                            r_req   <= 1'b1;
                            r_state <= DBG_ST_STEP_REQ;
                        end else begin
                            r_event <= 1'b1;
                            r_state <= DBG_ST_HALTED;
                        end
                    end
                end
                DBG_ST_RESUME: begin
                    if (!STOPPED || (PC != r_skip_addr)) r_state <= DBG_ST_RUN;
                end
                default: r_state <= DBG_ST_RUN;
            endcase
        end
    end

    assign CMD_READY      = w_ready;
    assign DEBUG_STOP     = r_stop;
    assign DEBUG_AT_BKP   = r_at_bkp;
    assign DEBUG_STEP_REQ = r_req;
    assign DEBUG_MODE     = r_mode;
    assign HALTED         = r_halted;
    assign EVENT          = r_event;
    assign BKP_HIT        = r_bkp_hit;

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller with a phase-decoder ACK responder.
`timescale 1ns/1ps
module tb_debug_controller;

    localparam int ADDR_W = 16;
    localparam int IDX_W  = 2;

    localparam logic [2:0] OP_STOP = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3;
    localparam logic [2:0] OP_SET  = 3'd4, OP_CLR = 3'd5, OP_MODE = 3'd6;

    logic              CLK = 1'b0;
    logic              RESETN = 1'b0;
    logic              CMD_VALID = 1'b0;
    logic              CMD_READY;
    logic [2:0]        CMD_OP = '0;
    logic [IDX_W-1:0]  CMD_IDX = '0;
    logic [ADDR_W-1:0] CMD_ARG = '0;
    logic [ADDR_W-1:0] PC = '0;
    logic              STOPPED = 1'b0;
    logic              ACK = 1'b0;
    logic              DEBUG_STOP, DEBUG_AT_BKP, DEBUG_STEP_REQ, DEBUG_MODE;
    logic              HALTED, EVENT;
    logic [IDX_W-1:0]  BKP_HIT;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned ev_cnt = 0, pair_cnt = 0, viol_cnt = 0;
    int unsigned ack_dly = 0;
    logic        prev_ack = 1'b0, prev_req = 1'b0;

    debug_controller #(
        .ADDR_W  (ADDR_W),
        .NUM_BKP (4),
        .CNT_W   (8)
    ) dut (
        .CLK            (CLK),
        .RESETN         (RESETN),
        .CMD_VALID      (CMD_VALID),
        .CMD_READY      (CMD_READY),
        .CMD_OP         (CMD_OP),
        .CMD_IDX        (CMD_IDX),
        .CMD_ARG        (CMD_ARG),
        .PC             (PC),
        .STOPPED        (STOPPED),
        .DEBUG_STEP_ACK (ACK),
        .DEBUG_STOP     (DEBUG_STOP),
        .DEBUG_AT_BKP   (DEBUG_AT_BKP),
        .DEBUG_STEP_REQ (DEBUG_STEP_REQ),
        .DEBUG_MODE     (DEBUG_MODE),
        .HALTED         (HALTED),
        .EVENT          (EVENT),
        .BKP_HIT        (BKP_HIT)
    );

    always #5 CLK = ~CLK;

    // Decoder model: ACK four cycles after REQ rises, drop ACK once REQ falls.
    always @(posedge CLK) begin
        if (DEBUG_STEP_REQ && !ACK) begin
            if (ack_dly == 3) begin
                ACK     <= 1'b1;
                ack_dly <= 0;
            end else begin
                ack_dly <= ack_dly + 1;
            end
        end else begin
            ack_dly <= 0;
            if (!DEBUG_STEP_REQ) ACK <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (EVENT) ev_cnt++;
        if (ACK && !prev_ack) pair_cnt++;
        if (DEBUG_STEP_REQ && ACK && !prev_req) viol_cnt++;
        prev_ack = ACK;
        prev_req = DEBUG_STEP_REQ;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_sig(input int unsigned s);
        case (s)
            0:       return DEBUG_AT_BKP;
            1:       return HALTED;
            2:       return DEBUG_STEP_REQ;
            default: return CMD_READY;
        endcase
    endfunction

    task automatic wait_high(input string tag, input int unsigned s, input int unsigned limit);
        int unsigned t = 0;
        while (!sel_sig(s) && t < limit) begin
            @(negedge CLK);
            t++;
        end
        check({tag, "_wait"}, {31'd0, sel_sig(s)}, 32'd1);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [IDX_W-1:0] idx,
                            input logic [ADDR_W-1:0] arg);
        CMD_OP    = op;
        CMD_IDX   = idx;
        CMD_ARG   = arg;
        CMD_VALID = 1'b1;
        wait_high("cmd_ready", 3, 50);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_OP    = '0;
    endtask

    task automatic run_steps(input string tag, input logic [ADDR_W-1:0] arg,
                             input int unsigned exp_pairs);
        int unsigned ev0 = ev_cnt, p0 = pair_cnt, v0 = viol_cnt, t = 0;
        send_cmd(OP_STEP, '0, arg);
        while (ev_cnt == ev0 && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        repeat (3) @(negedge CLK);
        check({tag, "_pairs"}, pair_cnt - p0, exp_pairs);
        check({tag, "_events"}, ev_cnt - ev0, 32'd1);
        check({tag, "_req_while_ack"}, viol_cnt - v0, 32'd0);
        check({tag, "_halted"}, {31'd0, HALTED}, 32'd1);
        check({tag, "_req_low"}, {31'd0, DEBUG_STEP_REQ}, 32'd0);
    endtask

    task automatic resume(input string tag, input logic [ADDR_W-1:0] new_pc);
        send_cmd(OP_RUN, '0, '0);
        check({tag, "_stop_low"}, {31'd0, DEBUG_STOP}, 32'd0);
        check({tag, "_halted_low"}, {31'd0, HALTED}, 32'd0);
        STOPPED = 1'b0;
        PC      = new_pc;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int unsigned ev0;

        repeat (2) @(negedge CLK);
        check("rst_ready", {31'd0, CMD_READY}, 32'd1);
        check("rst_outs", {25'd0, DEBUG_STOP, DEBUG_AT_BKP, DEBUG_STEP_REQ,
                           DEBUG_MODE, HALTED, EVENT, BKP_HIT}, 32'd0);
        RESETN = 1'b1;
        @(negedge CLK);

        // Breakpoint hit at 0x0040
        ev0 = ev_cnt;
        send_cmd(OP_SET, 2'd0, 16'h0040);
        PC = 16'h0040;
        STOPPED = 1'b1;
        @(negedge CLK);
        check("bkp_at_bkp", {31'd0, DEBUG_AT_BKP}, 32'd1);
        check("bkp_not_yet_halted", {31'd0, HALTED}, 32'd0);
        @(negedge CLK);
        check("halting_not_ready", {31'd0, CMD_READY}, 32'd0);
        @(negedge CLK);
        check("bkp_halted", {31'd0, HALTED}, 32'd1);
        check("bkp_event", {31'd0, EVENT}, 32'd1);
        check("bkp_hit0", {30'd0, BKP_HIT}, 32'd0);
        check("bkp_stop_held", {31'd0, DEBUG_STOP}, 32'd1);
        @(negedge CLK);
        check("bkp_event_pulse", {31'd0, EVENT}, 32'd0);
        check("bkp_single_event", ev_cnt - ev0, 32'd1);

        // Step sequences
        run_steps("step3", 16'd3, 3);
        run_steps("step0", 16'd0, 1);
        run_steps("step_hi_bits", 16'h0100, 1);
        run_steps("step255", 16'h01FF, 255);

        // RUN off the parked breakpoint, then re-hit it
        ev0 = ev_cnt;
        resume("run1", 16'h0040);
        check("skip_no_rehit", {31'd0, DEBUG_AT_BKP}, 32'd0);
        check("skip_running", {31'd0, CMD_READY}, 32'd1);
        check("skip_not_halted", {31'd0, HALTED}, 32'd0);
        PC = 16'h0041;
        repeat (2) @(negedge CLK);
        PC = 16'h0040;
        wait_high("rehit_bkp", 0, 5);
        STOPPED = 1'b1;
        wait_high("rehit_halt", 1, 10);
        repeat (2) @(negedge CLK);
        check("rehit_event", ev_cnt - ev0, 32'd1);
        check("rehit_idx", {30'd0, BKP_HIT}, 32'd0);

        send_cmd(OP_SET, 2'd2, 16'h0080);
        send_cmd(OP_SET, 2'd3, 16'h0080);
        check("setbkp_stays_halted", {31'd0, HALTED}, 32'd1);

        // STOP command with no breakpoint
        resume("run2", 16'h0100);
        check("run2_no_bkp", {31'd0, DEBUG_AT_BKP}, 32'd0);
        send_cmd(OP_STOP, '0, '0);
        check("stop_asserted", {31'd0, DEBUG_STOP}, 32'd1);
        check("stop_not_ready", {31'd0, CMD_READY}, 32'd0);
        repeat (2) @(negedge CLK);
        check("stop_wait_stopped", {31'd0, CMD_READY}, 32'd0);
        STOPPED = 1'b1;
        @(negedge CLK);
        check("stop_halted", {31'd0, HALTED}, 32'd1);
        check("stop_event", {31'd0, EVENT}, 32'd1);
        check("stop_ready", {31'd0, CMD_READY}, 32'd1);

        // STOP and breakpoint in the same cycle: lowest slot wins, one EVENT
        resume("run3", 16'h0080);
        wait_high("same_at_bkp", 0, 5);
        ev0 = ev_cnt;
        STOPPED = 1'b1;
        send_cmd(OP_STOP, '0, '0);
        wait_high("same_halt", 1, 10);
        repeat (3) @(negedge CLK);
        check("same_single_event", ev_cnt - ev0, 32'd1);
        check("same_bkp_hit", {30'd0, BKP_HIT}, 32'd2);

        send_cmd(OP_MODE, '0, 16'h0001);
        check("mode_set", {31'd0, DEBUG_MODE}, 32'd1);
        check("mode_state_kept", {31'd0, HALTED}, 32'd1);

        // Clearing slot 2 leaves slot 3 as the lowest match
        send_cmd(OP_CLR, 2'd2, '0);
        resume("run4", 16'h0090);
        PC = 16'h0080;
        wait_high("clr_at_bkp", 0, 5);
        STOPPED = 1'b1;
        wait_high("clr_halt", 1, 10);
        check("clr_bkp_hit", {30'd0, BKP_HIT}, 32'd3);

        // Asynchronous reset during a step request
        send_cmd(OP_STEP, '0, 16'd5);
        wait_high("rst_req_up", 2, 5);
        RESETN = 1'b0;
        #1;
        check("rst_req_drop", {31'd0, DEBUG_STEP_REQ}, 32'd0);
        check("rst_mode_clr", {31'd0, DEBUG_MODE}, 32'd0);
        check("rst_halted_clr", {31'd0, HALTED}, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        PC = 16'h0080;
        STOPPED = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_ready", {31'd0, CMD_READY}, 32'd1);
        check("post_rst_bkp_en", {31'd0, DEBUG_AT_BKP}, 32'd0);
        check("post_rst_no_halt", {31'd0, HALTED}, 32'd0);
        PC = 16'h0040;
        repeat (3) @(negedge CLK);
        check("post_rst_bkp0_en", {31'd0, DEBUG_AT_BKP}, 32'd0);
        send_cmd(OP_STEP, '0, 16'd1);
        repeat (3) @(negedge CLK);
        check("run_step_ignored", {31'd0, DEBUG_STEP_REQ}, 32'd0);
        check("run_step_no_halt", {31'd0, HALTED}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
